// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
package rom_arb_pkg;

    // Per-requester response slot state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        HELD     = 2'd2
    } slot_state_t;

    // Requester indices, also the encoding of last_grant.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Round-robin pick between two candidates; on contention the one that
    // was not granted last wins. With no candidates the result is REQ0.
    function automatic logic rr_pick(input logic cand0, input logic cand1,
                                     input logic last_grant);
        if (cand0 && cand1)
            return (last_grant == REQ1) ? REQ0 : REQ1;
        else if (cand1)
            return REQ1;
        else
            return REQ0;
    endfunction

endpackage

// File: rtl/rom_rsp_slot.sv
// One requester's response slot: tracks an outstanding ROM read, holds the
// returned word while the consumer stalls, and reports whether a new read
// may be accepted this cycle.
module rom_rsp_slot
    import rom_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              rsp_ready,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              eligible
);

    slot_state_t       state, state_nxt;
    logic              capture;
    logic [DATA_W-1:0] hold_q;

    // Slot state register; reset drops any in-flight or held response.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Hold register grabs the ROM word when the consumer stalls on it.
    always_ff @(posedge clk) begin
        if (capture)
            hold_q <= rom_dout;
    end

    // Next-state logic; a drain and a new accept may occur in the same cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = INFLIGHT;
            end
            INFLIGHT: begin
                if (rsp_ready) begin
                    state_nxt = accept ? INFLIGHT : IDLE;
                end else begin
                    state_nxt = HELD;
                    capture   = 1'b1;
                end
            end
            HELD: begin
                if (rsp_ready)
                    state_nxt = accept ? INFLIGHT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == INFLIGHT) || (state == HELD);
    assign rsp_data  = (state == HELD) ? hold_q : rom_dout;
    assign eligible  = (state == IDLE) || rsp_ready;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-address ROM between two read
// requesters, with a one-deep response slot per requester.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_req_valid,
    input  logic [ADDR_W-1:0] r0_req_addr,
    output logic              r0_req_ready,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_data,
    input  logic              r0_rsp_ready,

    input  logic              r1_req_valid,
    input  logic [ADDR_W-1:0] r1_req_addr,
    output logic              r1_req_ready,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_data,
    input  logic              r1_rsp_ready,

    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_dout
);

    logic              elig0, elig1;
    logic              cand0, cand1;
    logic              grant_idx;
    logic              accept0, accept1, any_accept;
    logic              last_grant;
    logic [ADDR_W-1:0] rom_addr_q;

    assign cand0 = r0_req_valid && elig0;
    assign cand1 = r1_req_valid && elig1;

    // Combinational round-robin selection among valid, eligible requesters.
    always_comb begin
        grant_idx = rr_pick(cand0, cand1, last_grant);
    end

    // No grants while reset is held so nothing is launched into a slot that
    // is being cleared.
    assign r0_req_ready = !reset && elig0 && (grant_idx == REQ0);
    assign r1_req_ready = !reset && elig1 && (grant_idx == REQ1);

    assign accept0    = r0_req_valid && r0_req_ready;
    assign accept1    = r1_req_valid && r1_req_ready;
    assign any_accept = accept0 || accept1;

    // The ROM address only moves on an accept, otherwise it parks on the
    // last address driven.
    assign rom_address = !any_accept ? rom_addr_q :
                         accept1     ? r1_req_addr : r0_req_addr;

    // Last-grant and parked ROM address, updated on every accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ1;
            rom_addr_q <= '0;
        end else if (any_accept) begin
            last_grant <= accept1 ? REQ1 : REQ0;
            rom_addr_q <= rom_address;
        end
    end

    rom_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept0),
        .rsp_ready (r0_rsp_ready),
        .rom_dout  (rom_dout),
        .rsp_valid (r0_rsp_valid),
        .rsp_data  (r0_rsp_data),
        .eligible  (elig0)
    );

    rom_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept1),
        .rsp_ready (r1_rsp_ready),
        .rom_dout  (rom_dout),
        .rsp_valid (r1_rsp_valid),
        .rsp_data  (r1_rsp_data),
        .eligible  (elig1)
    );

endmodule
